// File: rtl/vdp99_pkg.sv
// Shared vdp99 constants: VRAM read-return channel indices and default read latency.
package vdp99_pkg;

   localparam int CH_NAME    = 0;
   localparam int CH_PATTERN = 1;
   localparam int CH_COLOR   = 2;
   localparam int CH_SPRITE  = 3;

   localparam int VRAM_RD_LATENCY = 1;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// LATENCY-stage {vld, chan} delay line that aligns a read's channel tag with its returning VRAM data.
module vram_rd_tag_pipe #(
   parameter int LATENCY = 1,
   parameter int CHAN_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_vld,
   input  logic [CHAN_W-1:0] in_chan,
   output logic              out_vld,
   output logic [CHAN_W-1:0] out_chan
);

   logic [LATENCY-1:0]             vld_pipe;
   logic [LATENCY-1:0][CHAN_W-1:0] chan_pipe;

   // Only the valid bits need reset; a stale tag is harmless while its vld is 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_vld;
         for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      chan_pipe[0] <= in_chan;
      for (int i = 1; i < LATENCY; i++) chan_pipe[i] <= chan_pipe[i-1];
   end

   assign out_vld  = vld_pipe[LATENCY-1];
   assign out_chan = chan_pipe[LATENCY-1];

endmodule

// File: rtl/vram_rd_demux_n.sv
// VRAM read-return demux: routes returning bytes into per-channel holding registers with valid/ack.
// Overrun flags are built only when VRAM_RD_DEMUX_OVERRUN_EN is defined; otherwise overrun reads 0.
module vram_rd_demux_n
   import vdp99_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int NCHAN   = 4,
   parameter  int LATENCY = VRAM_RD_LATENCY,
   localparam int CHAN_W  = $clog2(NCHAN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rd_tick,
   input  logic [CHAN_W-1:0]       rd_chan,
   input  logic [DATA_W-1:0]       din,
   output logic [NCHAN*DATA_W-1:0] dout,
   output logic [NCHAN-1:0]        dout_valid,
   input  logic [NCHAN-1:0]        dout_ack,
   output logic [NCHAN-1:0]        overrun,
   input  logic [NCHAN-1:0]        overrun_clr
);

   logic              tag_vld;
   logic [CHAN_W-1:0] tag_chan;

   vram_rd_tag_pipe #(
      .LATENCY (LATENCY),
      .CHAN_W  (CHAN_W)
   ) u_tag_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (rd_tick),
      .in_chan  (rd_chan),
      .out_vld  (tag_vld),
      .out_chan (tag_chan)
   );

   // Tags >= NCHAN match no channel below, so they drop out silently.
   for (genvar k = 0; k < NCHAN; k++) begin : g_ch
      logic              cap;
      logic              take;
      logic [DATA_W-1:0] data_q;
      logic              valid_q;

      assign cap  = tag_vld && (tag_chan == CHAN_W'(k));
      assign take = dout_ack[k] && valid_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else if (cap) begin
            data_q  <= din;
            valid_q <= 1'b1;
         end else if (take) begin
            valid_q <= 1'b0;
         end
      end

      assign dout[k*DATA_W +: DATA_W] = data_q;
      assign dout_valid[k]            = valid_q;

`ifdef VRAM_RD_DEMUX_OVERRUN_EN
      logic ovr_q;

      // An ack on the capture edge consumed the old byte, so that is not an overrun.
      always_ff @(posedge clk) begin
         if (reset)                           ovr_q <= 1'b0;
         else if (cap && valid_q && !take)    ovr_q <= 1'b1;
         else if (overrun_clr[k])             ovr_q <= 1'b0;
      end

      assign overrun[k] = ovr_q;
`else
      assign overrun[k] = 1'b0;
`endif
   end

`ifndef VRAM_RD_DEMUX_OVERRUN_EN
   logic unused_clr;
   assign unused_clr = ^overrun_clr;
`endif

endmodule

// File: doc/vram_rd_demux_n.md
# vram_rd_demux_n

Parametrised VRAM read-return demultiplexer for the vdp99 video pipeline. It routes each VRAM read result to one of several requesting channels: name table, pattern, colour, sprite, CPU port. A channel tag travels with the read strobe through a delay line matching the configured VRAM read latency, and the returned byte is captured into that channel's holding register. Each channel gets a valid/ack handshake, so slow consumers can be served alongside per-pixel fetchers.

## Interface
Parameters:
- DATA_W, 8, VRAM data width.
- NCHAN, 4, number of requesting channels; minimum 2.
- LATENCY, 1, cycles from rd_tick to din valid; minimum 1.
- CHAN_W (localparam), $clog2(NCHAN), tag width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rd_tick  in  1  a VRAM read is issued this cycle.
- rd_chan  in  CHAN_W  channel tag for that read; sampled with rd_tick.
- din  in  DATA_W  VRAM read data.
- dout  out  NCHAN*DATA_W  per-channel holding registers, flattened; channel k occupies bits [k*DATA_W +: DATA_W].
- dout_valid  out  NCHAN  channel holds unconsumed data.
- dout_ack  in  NCHAN  consumer takes the data; acts only when the matching valid bit is 1.
- overrun  out  NCHAN  sticky overwrite flag.
- overrun_clr  in  NCHAN  clears the matching overrun bit.

## Operation
- Tag pipeline: LATENCY stages of {vld, chan}.
  - Stage 0 loads {rd_tick, rd_chan} every cycle.
  - Stage i loads stage i-1.
- Capture: on the edge where the last stage holds vld=1, load din into dout[chan] and set dout_valid[chan].
- Out-of-range tag: rd_chan >= NCHAN travels the pipe but captures nothing and alters no flags.
- Ack: dout_ack[k] with dout_valid[k]=1 clears valid[k] on the next edge. Ack with valid=0 is ignored.
- Simultaneous capture and ack on the same channel: new data loads, valid stays 1, no overrun (the ack consumed the old data).
- Capture with valid=1 and no ack: data is overwritten (newest wins), valid stays 1, overrun[k] is set.
- overrun_clr[k] clears overrun[k]. If a set condition occurs on the same edge, set wins.
- Back-to-back rd_tick every cycle is supported. There is one capture per cycle and no loss in the pipe.
- Channels are independent. Only one channel can capture per cycle.

## Timing
- Reset values: dout all 0, dout_valid 0, overrun 0, all tag stages vld=0.
- Reset mid-operation: in-flight reads are discarded. A read issued in the reset cycle never captures.
- Read cycle: rd_tick is high in cycle N.
  - din is sampled at the clk edge ending cycle N+LATENCY.
  - dout and dout_valid change visibly in cycle N+LATENCY+1.
  - With LATENCY=1 this is a 2-cycle rd_tick-to-dout latency.
- Ack timing: dout_ack sampled in cycle M makes valid low in cycle M+1.
- Outputs are registered only; there is no combinational path from input to output.

## Configuration
- VRAM_RD_DEMUX_OVERRUN_EN defined:
  - Overrun detection and clearing operate as above.
- VRAM_RD_DEMUX_OVERRUN_EN undefined:
  - overrun is constant 0 and overrun_clr is ignored.
  - Overwrite still occurs silently.
  - The port list is identical in both cases.

## Structure
- Shared package vdp99_pkg holds:
  - the channel index constants CH_NAME=0, CH_PATTERN=1, CH_COLOR=2, CH_SPRITE=3;
  - the default VRAM_RD_LATENCY=1.
- Sub-module vram_rd_tag_pipe: parametrised LATENCY-stage {vld, chan} delay line with synchronous reset of the vld bits. Instantiated once.
- Per-channel registers are built with a generate loop in the top module.

## Test plan
- Basic capture: reset, then rd_tick with rd_chan=2 in cycle 5, din=8'hA5 in cycle 6 (LATENCY=1).
  - Required: dout[2]=A5 and dout_valid=4'b0100 in cycle 7.
  - Required: the other channels stay 0.
- Back-to-back reads: rd_tick in cycles 10–13 with chans 0,1,2,3 and din 11,22,33,44 delayed by one cycle.
  - Required: all four captured, dout_valid=4'b1111, overrun=0.
- Overrun: two reads to chan 1 (din 55 then 66) with no ack.
  - Required: dout[1]=66, valid[1]=1, overrun[1]=1 with the macro defined, 0 without.
  - Then overrun_clr[1] → overrun[1]=0 next cycle.
- Ack collision: valid[0]=1, then ack[0] asserted on the same edge as a new capture of 77 to chan 0.
  - Required: valid[0]=1, dout[0]=77, overrun[0]=0.
- LATENCY=3 with NCHAN=5: rd_tick in cycle 20 with chan=4, din=9C in cycle 23.
  - Required: dout[4]=9C in cycle 24.
  - Required: a read with chan 6 and NCHAN=8 sizing changes nothing.
- Reset mid-flight: rd_tick in cycle 30, reset in cycle 30.
  - Required: no capture, all outputs 0 in cycle 31 onward.
